sequence_player: RTL and testbench

Plays a stored colour sequence on one-hot LED outputs. Each symbol is lit for a fixed number of 0.25 s ticks, followed by a dark gap. The time base is the square-wave output of the 0.25 s delay stage, which toggles every 12 500 000 `CLOCK_50` cycles. The block sits directly downstream of that stage and converts every edge of its output into a single-cycle tick.

---
 rtl/salval_pkg.sv | 26 ++
 rtl/edge_tick.sv | 20 ++
 rtl/sequence_player.sv | 138 +++++++++++++
 tb/tb_sequence_player.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/salval_pkg.sv
// Shared definitions for the LED sequence player and related delay-stage consumers:
// FSM state encoding, colour indices and a bit-width helper.
package salval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int RED    = 0;
  localparam int GREEN  = 1;
  localparam int BLUE   = 2;
  localparam int YELLOW = 3;

  // Number of bits needed to hold the value itself (clogb2(16) == 5), never less than 1.
  function automatic int clogb2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Converts every edge of a same-domain square wave into a single-cycle pulse.
// While sclr is high the delay register tracks src, so releasing clear never emits a pulse.
module edge_tick (
  input  logic clk,
  input  logic sclr,
  input  logic src,
  output logic pulse
);

  logic src_d;

  // NOTE: sequential state always uses non-blocking assignment so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    src_d <= src;
  end

  assign pulse = (src ^ src_d) & ~sclr;

endmodule

// File: rtl/sequence_player.sv
// Plays a captured colour sequence on one-hot LEDs: each symbol lit for ON_TICKS ticks,
// then dark for GAP_TICKS ticks. All outputs are registered.
module sequence_player
  import salval_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int SYM_W     = 2,
  parameter int ON_TICKS  = 2,
  parameter int GAP_TICKS = 1,
  parameter int LEN_W     = clogb2(MAX_LEN)
) (
  input  logic                     CLOCK_50,
  input  logic                     sclr,
  input  logic                     tick_src,
  input  logic                     start,
  input  logic [LEN_W-1:0]         length,
  input  logic [MAX_LEN*SYM_W-1:0] seq,
  output logic [2**SYM_W-1:0]      leds,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         idx
);

  localparam int LED_W    = 2**SYM_W;
  localparam int SEQ_W    = MAX_LEN * SYM_W;
  localparam int TCNT_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TCNT_W   = clogb2(TCNT_MAX);

  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [TCNT_W-1:0] ON_L      = TCNT_W'(ON_TICKS);
  localparam logic [TCNT_W-1:0] GAP_L     = TCNT_W'(GAP_TICKS);

  logic tick;

  edge_tick u_edge_tick (
    .clk   (CLOCK_50),
    .sclr  (sclr),
    .src   (tick_src),
    .pulse (tick)
  );

  state_t             state, state_next;
  logic [LEN_W-1:0]   idx_next;
  logic [TCNT_W-1:0]  tcnt, tcnt_next;
  logic [LEN_W-1:0]   len_r, len_next;
  logic [SEQ_W-1:0]   seq_r, seq_next;
  logic [LED_W-1:0]   leds_next;
  logic               busy_next, done_next;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    idx_next   = idx;
    tcnt_next  = tcnt;
    len_next   = len_r;
    seq_next   = seq_r;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        // A tick coincident with the accept is deliberately not counted.
        if (start) begin
          if (length != '0) begin
            len_next   = (length > MAX_LEN_L) ? MAX_LEN_L : length;
            seq_next   = seq;
            idx_next   = '0;
            tcnt_next  = '0;
            state_next = ON;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ON: begin
        if (tick) begin
          if (tcnt + 1'b1 == ON_L) begin
            tcnt_next  = '0;
            state_next = GAP;
          end else begin
            tcnt_next = tcnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (tcnt + 1'b1 == GAP_L) begin
            tcnt_next = '0;
            if (idx == len_r - 1'b1) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              idx_next   = idx + 1'b1;
              state_next = ON;
            end
          end else begin
            tcnt_next = tcnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are computed from next-state values so the registered copies line up
    // with the state they describe.
    busy_next = (state_next != IDLE);
    leds_next = '0;
    if (state_next == ON) begin
      leds_next = LED_W'(1) << seq_next[idx_next*SYM_W +: SYM_W];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (sclr) begin
      state <= IDLE;
      idx   <= '0;
      tcnt  <= '0;
      leds  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      tcnt  <= tcnt_next;
      leds  <= leds_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // NOTE: the capture registers are left out of reset; they are only read after an
  // accepted start has loaded them, so clearing them would buy nothing.
  always_ff @(posedge CLOCK_50) begin
    len_r <= len_next;
    seq_r <= seq_next;
  end

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player: table-driven start responses, hand-written
// corner sequences and randomized plays checked against a phase-list reference model.
module tb_sequence_player;
  import salval_pkg::*;

  localparam int MAX_LEN   = 16;
  localparam int SYM_W     = 2;
  localparam int ON_TICKS  = 2;
  localparam int GAP_TICKS = 1;
  localparam int LEN_W     = clogb2(MAX_LEN);
  localparam int SEQ_W     = MAX_LEN * SYM_W;
  localparam int LED_W     = 2**SYM_W;
  localparam int TP        = 4;   // cycles per tick (tick_src toggles every 4 cycles)

  logic             clk      = 1'b0;
  logic             sclr     = 1'b1;
  logic             tick_src = 1'b1;
  logic             tick_en  = 1'b0;
  logic             start    = 1'b0;
  logic [LEN_W-1:0] length   = '0;
  logic [SEQ_W-1:0] seq      = '0;
  logic [LED_W-1:0] leds;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [LED_W-1:0] leds;
    logic [LEN_W-1:0] idx;
    logic             busy;
    logic             done;
  } obs_t;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [SYM_W-1:0] sym0;
    logic [LED_W-1:0] exp_leds;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  sequence_player #(
    .MAX_LEN   (MAX_LEN),
    .SYM_W     (SYM_W),
    .ON_TICKS  (ON_TICKS),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .CLOCK_50 (clk),
    .sclr     (sclr),
    .tick_src (tick_src),
    .start    (start),
    .length   (length),
    .seq      (seq),
    .leds     (leds),
    .busy     (busy),
    .done     (done),
    .idx      (idx)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TP) @(negedge clk);
      if (tick_en) tick_src = ~tick_src;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.leds = leds;
    o.idx  = idx;
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  // Reference model: the expected playback is a list of phases (lit symbol i, then dark
  // with idx still i). Observed outputs are run-length encoded and compared phase by phase.
  task automatic play(input logic [SEQ_W-1:0] s, input logic [LEN_W-1:0] l,
                      input int inject, input string tag);
    obs_t cur;
    obs_t exp_o;
    obs_t run_val[$];
    int   run_len[$];
    int   eff, limit, n_runs;
    bit   got_done;
    logic [SYM_W-1:0] sym;

    eff      = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
    limit    = eff * (ON_TICKS + GAP_TICKS) * TP + 4 * TP;
    got_done = 1'b0;
    cur      = '0;
    seq      = s;
    length   = l;
    start    = 1'b1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      cur   = sample();
      start = (c == inject);
      if (c == 0) begin
        seq    = ~s;
        length = '1;
      end
      if (cur.done) begin
        got_done = 1'b1;
        break;
      end
      if (run_val.size() != 0 && run_val[$] == cur) run_len[$] = run_len[$] + 1;
      else begin
        run_val.push_back(cur);
        run_len.push_back(1);
      end
    end
    start = 1'b0;

    check($sformatf("%s done seen", tag), 32'(got_done), 32'd1);
    if (got_done) begin
      exp_o = '{leds: '0, idx: LEN_W'(eff - 1), busy: 1'b0, done: 1'b1};
      check($sformatf("%s end outputs", tag), 32'(cur), 32'(exp_o));
    end else begin
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
    end

    check($sformatf("%s phase count", tag), 32'(run_val.size()), 32'(2 * eff));
    n_runs = (run_val.size() < 2 * eff) ? run_val.size() : 2 * eff;
    for (int i = 0; i < n_runs; i++) begin
      sym        = s[(i / 2) * SYM_W +: SYM_W];
      exp_o.leds = (i % 2 == 0) ? (LED_W'(1) << sym) : '0;
      exp_o.idx  = LEN_W'(i / 2);
      exp_o.busy = 1'b1;
      exp_o.done = 1'b0;
      check($sformatf("%s phase %0d value", tag, i), 32'(run_val[i]), 32'(exp_o));
      if (i == 0)
        check($sformatf("%s first lit length %0d in range", tag, run_len[i]),
              32'(run_len[i] >= (ON_TICKS - 1) * TP && run_len[i] <= ON_TICKS * TP), 32'd1);
      else if (i % 2 == 1)
        check($sformatf("%s phase %0d gap length", tag, i), 32'(run_len[i]), 32'(GAP_TICKS * TP));
      else
        check($sformatf("%s phase %0d lit length", tag, i), 32'(run_len[i]), 32'(ON_TICKS * TP));
    end
  endtask

  initial begin
    vec_t vecs[5];
    bit   found;
    logic [SEQ_W-1:0] s;
    logic [LEN_W-1:0] l;
    int   eff, inj;

    vecs[0] = '{len: 5'd0,  sym0: 2'(BLUE),   exp_leds: 4'b0000, exp_busy: 1'b0, exp_done: 1'b1};
    vecs[1] = '{len: 5'd1,  sym0: 2'(RED),    exp_leds: 4'b0001, exp_busy: 1'b1, exp_done: 1'b0};
    vecs[2] = '{len: 5'd3,  sym0: 2'(BLUE),   exp_leds: 4'b0100, exp_busy: 1'b1, exp_done: 1'b0};
    vecs[3] = '{len: 5'd31, sym0: 2'(YELLOW), exp_leds: 4'b1000, exp_busy: 1'b1, exp_done: 1'b0};
    vecs[4] = '{len: 5'd16, sym0: 2'(GREEN),  exp_leds: 4'b0010, exp_busy: 1'b1, exp_done: 1'b0};

    // Reset values: sclr held with tick_src high, then released; no tick may appear.
    repeat (5) @(negedge clk);
    sclr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("reset outputs c%0d", c), 32'(sample()), 32'd0);
    end
    tick_en = 1'b1;

    // Start response, one cycle after the accepting edge.
    foreach (vecs[v]) begin
      s            = $urandom;
      s[SYM_W-1:0] = vecs[v].sym0;
      seq          = s;
      length       = vecs[v].len;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("vec%0d leds", v), 32'(leds), 32'(vecs[v].exp_leds));
      check($sformatf("vec%0d busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d idx", v), 32'(idx), 32'd0);
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
    end

    // Zero length: done pulses once, nothing else moves.
    seq    = $urandom;
    length = '0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero len done pulse", 32'(sample()), 32'(obs_t'{leds: '0, idx: '0, busy: 1'b0, done: 1'b1}));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("zero len quiet c%0d", c), 32'(sample()), 32'd0);
    end

    // Three-symbol play {2,0,1}, then back-to-back start in the done cycle.
    s          = $urandom;
    s[5:0]     = 6'b10_00_01;
    play(s, 5'd3, -1, "three");
    s = $urandom;
    play(s, 5'd2, -1, "back2back");

    // Start while busy is ignored.
    s      = $urandom;
    s[5:0] = 6'b11_01_10;
    play(s, 5'd3, 15, "busy start");

    // Length clamp.
    play($urandom, 5'd31, -1, "clamp");

    // Reset during the gap of symbol 1, then a fresh replay from idx 0.
    seq    = $urandom;
    length = 5'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy && idx == 5'd1 && leds == '0) begin
        found = 1'b1;
        break;
      end
    end
    check("reach gap of symbol 1", 32'(found), 32'd1);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check("mid-play reset outputs", 32'(sample()), 32'd0);
    @(negedge clk);
    check("after reset stays idle", 32'(sample()), 32'd0);
    play($urandom, 5'd2, -1, "replay");

    // Randomized plays, some with an ignored start mid-play.
    for (int r = 0; r < 6; r++) begin
      s   = $urandom;
      l   = (r == 5) ? LEN_W'($urandom_range(17, 31)) : LEN_W'($urandom_range(1, 5));
      eff = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, eff * 12 - 4) : -1;
      play(s, l, inj, $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
